// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID->EX pipeline register that sits directly behind the register file.
// Each cycle it captures the decoded instruction together with both source
// operands. A write-back that commits on the same edge is routed straight
// into the operand capture, so EX never sees the stale register-file value.
// A load in EX whose destination feeds the ID instruction inserts one bubble.
// A branch flush also inserts a bubble, and a downstream hold freezes the stage.
// Every inserted bubble is counted in a saturating counter.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   id_*            decoded instruction from ID (valid, pc, rs, rt, rd, imm, ctrl)
//   rf_data1/2      combinational register-file reads for id_rs / id_rt
//   wb_*            write-back port (enable, index, data)
//   flush           kill the ID instruction (taken branch / jump)
//   ex_stall        EX cannot accept; hold this stage
//   stall_id        freeze PC and IF/ID (combinational)
//   ex_*            registered instruction presented to EX
//   bubble_cnt      saturating count of inserted bubbles
//
// ctrl bus: [0]=reg_write [1]=mem_read [2]=mem_write [3]=mem_to_reg
//           [4]=alu_src   [5]=reg_dst  [7:6]=alu_op
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_data1,
  input  logic [31:0]       rf_data2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_write_reg,
  input  logic [31:0]       wb_write_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_data1,
  output logic [31:0]       ex_data2,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int MEM_READ_BIT = 1;

  logic [31:0] d1;
  logic [31:0] d2;
  logic        load_use;
  logic        bubble;

  // Same-edge write-back bypass. Index 0 is not special-cased because the
  // register file itself accepts writes to r0.
  always_comb begin
    d1 = rf_data1;
    d2 = rf_data2;
    if (wb_reg_write && (wb_write_reg == id_rs)) d1 = wb_write_data;
    if (wb_reg_write && (wb_write_reg == id_rt)) d2 = wb_write_data;
  end

  // The bubble drops ex_valid, so the hazard clears on the retry cycle and
  // the penalty is exactly one bubble.
  always_comb begin
    load_use = id_valid & ex_valid & ex_ctrl[MEM_READ_BIT] &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
    stall_id = load_use | ex_stall;
    bubble   = flush | load_use;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_data1   <= '0;
      ex_data2   <= '0;
      bubble_cnt <= '0;
    end else if (ex_stall) begin
      // hold everything; flush and load-use are ignored this cycle
    end else if (bubble) begin
      // payload fields are don't-care on a bubble and simply keep their value
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_data1 <= d1;
      ex_data2 <= d2;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush, ex_stall;

  logic        stall_id, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_data1, ex_data2;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  logic        s_stall_id, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_imm, s_ex_data1, s_ex_data2;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [7:0]  s_ex_ctrl;
  logic [3:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .flush(flush), .ex_stall(ex_stall),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .bubble_cnt(bubble_cnt)
  );

  // narrow-counter instance for the saturation sequence
  id_ex_stage #(.CTRL_W(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .flush(flush), .ex_stall(ex_stall),
    .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl),
    .ex_data1(s_ex_data1), .ex_data2(s_ex_data2), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic        rst, valid, flush, stall, wbw;
    logic [31:0] pc, imm, rf1, rf2, wdata;
    logic [4:0]  rs, rt, rd, wreg;
    logic [7:0]  ctrl;
    logic        chk_sid, e_sid, e_valid, chk_data;
    logic [7:0]  e_ctrl;
    logic [15:0] e_cnt;
    logic [31:0] e_pc, e_imm, e_d1, e_d2;
  } vec_t;

  vec_t cur;
  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic vi(input logic r, v, f, s, input logic [31:0] pc, input logic [4:0] rs,
                    rt, rd, input logic [7:0] ctrl, input logic [31:0] imm, rf1, rf2,
                    input logic wbw, input logic [4:0] wreg, input logic [31:0] wdata);
    cur.rst = r; cur.valid = v; cur.flush = f; cur.stall = s; cur.pc = pc;
    cur.rs = rs; cur.rt = rt; cur.rd = rd; cur.ctrl = ctrl; cur.imm = imm;
    cur.rf1 = rf1; cur.rf2 = rf2; cur.wbw = wbw; cur.wreg = wreg; cur.wdata = wdata;
  endtask

  task automatic ve(input logic cs, sid, valid, input logic [7:0] ctrl, input logic [15:0] cnt);
    cur.chk_sid = cs; cur.e_sid = sid; cur.e_valid = valid; cur.e_ctrl = ctrl;
    cur.e_cnt = cnt; cur.chk_data = 1'b0;
    cur.e_pc = '0; cur.e_imm = '0; cur.e_d1 = '0; cur.e_d2 = '0;
    tv.push_back(cur);
  endtask

  task automatic ved(input logic cs, sid, valid, input logic [7:0] ctrl, input logic [15:0] cnt,
                     input logic [31:0] pc, imm, d1, d2);
    cur.chk_sid = cs; cur.e_sid = sid; cur.e_valid = valid; cur.e_ctrl = ctrl;
    cur.e_cnt = cnt; cur.chk_data = 1'b1;
    cur.e_pc = pc; cur.e_imm = imm; cur.e_d1 = d1; cur.e_d2 = d2;
    tv.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; id_valid = v.valid; flush = v.flush; ex_stall = v.stall;
    id_pc = v.pc; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_ctrl = v.ctrl;
    id_imm = v.imm; rf_data1 = v.rf1; rf_data2 = v.rf2;
    wb_reg_write = v.wbw; wb_write_reg = v.wreg; wb_write_data = v.wdata;
  endtask

  initial begin
    // reset with garbage inputs
    vi(1,1,1,0,32'hFFFFFFFF,31,31,31,8'hFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,1,31,32'hAAAAAAAA);
    ved(0,0,0,8'h00,0,0,0,0,0);
    vi(1,1,1,0,32'hFFFFFFFF,31,31,31,8'hFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,1,31,32'hAAAAAAAA);
    ved(1,0,0,8'h00,0,0,0,0,0);
    // bypass
    vi(0,1,0,0,32'h100,5,7,9,8'h01,32'h10,5,32'h77,1,5,32'hDEADBEEF);
    ved(1,0,1,8'h01,0,32'h100,32'h10,32'hDEADBEEF,32'h77);
    vi(0,1,0,0,32'h104,5,7,9,8'h01,32'h14,5,32'h77,1,6,32'hDEADBEEF);
    ved(1,0,1,8'h01,0,32'h104,32'h14,5,32'h77);
    vi(0,1,0,0,32'h108,1,6,2,8'h01,32'h18,32'h11,32'h22,1,6,32'hCAFE0000);
    ved(1,0,1,8'h01,0,32'h108,32'h18,32'h11,32'hCAFE0000);
    vi(0,1,0,0,32'h10C,1,1,2,8'h01,32'h1C,32'h33,32'h44,0,1,32'hBAD0BAD0);
    ved(1,0,1,8'h01,0,32'h10C,32'h1C,32'h33,32'h44);
    vi(0,1,0,0,32'h110,0,0,0,8'h01,32'h20,0,0,1,0,32'h12345678);
    ved(1,0,1,8'h01,0,32'h110,32'h20,32'h12345678,32'h12345678);
    // load-use on rs: lw rt=3 then add rs=3
    vi(0,1,0,0,32'h114,2,3,0,8'h1B,32'h24,32'h200,32'h300,0,0,0);
    ved(1,0,1,8'h1B,0,32'h114,32'h24,32'h200,32'h300);
    vi(0,1,0,0,32'h118,3,4,5,8'h21,32'h28,32'h30,32'h40,0,0,0);
    ve(1,1,0,8'h00,1);
    vi(0,1,0,0,32'h118,3,4,5,8'h21,32'h28,32'h30,32'h40,1,3,32'h99);
    ved(1,0,1,8'h21,1,32'h118,32'h28,32'h99,32'h40);
    // invalid load: ctrl zeroed, not counted
    vi(0,0,0,0,32'h11C,4,4,4,8'hFF,32'h2C,32'h50,32'h60,0,0,0);
    ved(1,0,0,8'h00,1,32'h11C,32'h2C,32'h50,32'h60);
    // lw then an invalid ID slot that matches: no hazard
    vi(0,1,0,0,32'h120,1,8,0,8'h02,32'h30,1,2,0,0,0);
    ved(1,0,1,8'h02,1,32'h120,32'h30,1,2);
    vi(0,0,0,0,32'h124,8,8,0,8'h21,32'h34,5,6,0,0,0);
    ved(1,0,0,8'h00,1,32'h124,32'h34,5,6);
    // load-use on rt
    vi(0,1,0,0,32'h128,1,8,0,8'h02,32'h38,7,8,0,0,0);
    ved(1,0,1,8'h02,1,32'h128,32'h38,7,8);
    vi(0,1,0,0,32'h12C,1,8,9,8'h21,32'h3C,9,10,0,0,0);
    ve(1,1,0,8'h00,2);
    vi(0,1,0,0,32'h12C,1,8,9,8'h21,32'h3C,9,10,0,0,0);
    ved(1,0,1,8'h21,2,32'h12C,32'h3C,9,10);
    // lw followed by a non-dependent instruction
    vi(0,1,0,0,32'h130,1,8,0,8'h02,32'h40,32'hA,32'hB,0,0,0);
    ved(1,0,1,8'h02,2,32'h130,32'h40,32'hA,32'hB);
    vi(0,1,0,0,32'h134,1,2,3,8'h21,32'h44,32'hC,32'hD,0,0,0);
    ved(1,0,1,8'h21,2,32'h134,32'h44,32'hC,32'hD);
    // flush
    vi(0,1,1,0,32'h138,1,2,3,8'h21,32'h48,32'hE,32'hF,0,0,0);
    ve(1,0,0,8'h00,3);
    vi(0,1,0,0,32'h200,6,7,8,8'h85,32'h50,32'h66,32'h77,0,0,0);
    ved(1,0,1,8'h85,3,32'h200,32'h50,32'h66,32'h77);
    // hold for 3 cycles with flush and changing inputs
    vi(0,1,1,1,32'h300,1,2,3,8'hFE,32'h1,32'h1,32'h1,0,0,0);
    ved(1,1,1,8'h85,3,32'h200,32'h50,32'h66,32'h77);
    vi(0,1,1,1,32'h304,7,6,5,8'h02,32'h2,32'h2,32'h2,1,7,32'h5);
    ved(1,1,1,8'h85,3,32'h200,32'h50,32'h66,32'h77);
    vi(0,0,1,1,32'h308,9,9,9,8'h7F,32'h3,32'h3,32'h3,1,6,32'h1);
    ved(1,1,1,8'h85,3,32'h200,32'h50,32'h66,32'h77);
    vi(0,1,0,0,32'h20C,7,6,5,8'h40,32'h54,32'h1234,32'h5678,0,0,0);
    ved(1,0,1,8'h40,3,32'h20C,32'h54,32'h1234,32'h5678);
    // flush and load-use together: a single bubble
    vi(0,1,0,0,32'h210,2,3,0,8'h0B,32'h58,1,2,0,0,0);
    ved(1,0,1,8'h0B,3,32'h210,32'h58,1,2);
    vi(0,1,1,0,32'h214,3,4,5,8'h21,32'h5C,1,2,0,0,0);
    ve(1,1,0,8'h00,4);
    // reset while a hazard and a hold are both pending
    vi(0,1,0,0,32'h218,2,3,0,8'h0B,32'h60,3,4,0,0,0);
    ved(1,0,1,8'h0B,4,32'h218,32'h60,3,4);
    vi(1,1,0,1,32'h21C,3,4,5,8'h21,32'h64,5,6,0,0,0);
    ved(1,1,0,8'h00,0,0,0,0,0);
    vi(0,1,0,0,32'h21C,3,4,5,8'h21,32'h64,5,6,0,0,0);
    ved(1,0,1,8'h21,0,32'h21C,32'h64,5,6);

    @(negedge clk);
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].chk_sid) chk("stall_id", i, {31'd0, stall_id}, {31'd0, tv[i].e_sid});
      @(posedge clk);
      #1;
      chk("ex_valid", i, {31'd0, ex_valid}, {31'd0, tv[i].e_valid});
      chk("ex_ctrl", i, {24'd0, ex_ctrl}, {24'd0, tv[i].e_ctrl});
      chk("bubble_cnt", i, {16'd0, bubble_cnt}, {16'd0, tv[i].e_cnt});
      chk("sat_bubble_cnt", i, {28'd0, s_bubble_cnt}, {28'd0, tv[i].e_cnt[3:0]});
      if (tv[i].chk_data) begin
        chk("ex_pc", i, ex_pc, tv[i].e_pc);
        chk("ex_imm", i, ex_imm, tv[i].e_imm);
        chk("ex_data1", i, ex_data1, tv[i].e_d1);
        chk("ex_data2", i, ex_data2, tv[i].e_d2);
      end
      @(negedge clk);
    end

    // saturation: 20 flushes into a 4-bit counter, then reset
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b1;
    @(posedge clk); #1;
    chk("sat_reset_cnt", 100, {28'd0, s_bubble_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk("sat_cnt", 100 + k, {28'd0, s_bubble_cnt}, (k > 15) ? 32'd15 : k);
      chk("wide_cnt", 100 + k, {16'd0, bubble_cnt}, k);
      @(negedge clk);
    end
    flush = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("sat_after_rst", 200, {28'd0, s_bubble_cnt}, 32'd0);
    chk("wide_after_rst", 200, {16'd0, bubble_cnt}, 32'd0);
    chk("valid_after_rst", 200, {31'd0, ex_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
